// File: rtl/riscv_ctrl_fsm_if.sv
// Bundle between fetch/datapath and the RV64 control sequencer.
// Handshake: a transfer happens on a rising clk edge where instr_valid && instr_ready;
// fetch holds instr_in/instr_valid stable until that edge, and the sequencer only
// raises instr_ready while idle. mem_ack is a single-cycle completion strobe from data memory.
interface riscv_ctrl_fsm_if #(
  parameter int CNT_W = 32
);
  logic [31:0]      instr_in;
  logic             instr_valid;
  logic             instr_ready;
  logic             mem_ack;
  logic [31:0]      instruction;
  logic             RegWrite;
  logic             ALUSrc;
  logic [3:0]       ALUop;
  logic             MemWrite;
  logic             MemRead;
  logic             MemtoReg;
  logic             illegal;
  logic             mem_err;
  logic [CNT_W-1:0] retired;

  // Fetch / memory / datapath side
  modport master (
    output instr_in, instr_valid, mem_ack,
    input  instr_ready, instruction, RegWrite, ALUSrc, ALUop,
           MemWrite, MemRead, MemtoReg, illegal, mem_err, retired
  );

  // Sequencer side
  modport slave (
    input  instr_in, instr_valid, mem_ack,
    output instr_ready, instruction, RegWrite, ALUSrc, ALUop,
           MemWrite, MemRead, MemtoReg, illegal, mem_err, retired
  );
endinterface

// File: rtl/riscv_ctrl_fsm.sv
// Multi-cycle control sequencer for the RV64 load/store/ALU datapath.
// Walks each accepted instruction through DECODE/EXEC/(MEM)/WB. All outputs
// are functions of registered state and the latched instruction only.
module riscv_ctrl_fsm #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  riscv_ctrl_fsm_if.slave       bus,
  output logic [2:0]            dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    K_ILL = 3'd0,
    K_R   = 3'd1,
    K_I   = 3'd2,
    K_LD  = 3'd3,
    K_SD  = 3'd4
  } kind_t;

  localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;

  state_t           state_q, state_d;
  logic [31:0]      instr_q, instr_d;
  logic [7:0]       tmo_q, tmo_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             mem_err_q, mem_err_d;

  kind_t            kind;
  logic [3:0]       dec_op;
  logic             dec_src;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode = instr_q[6:0];
  assign funct3 = instr_q[14:12];
  assign funct7 = instr_q[31:25];

  // Classify the latched instruction and derive its ALU controls
  always_comb begin
    kind    = K_ILL;
    dec_op  = OP_ADD;
    dec_src = 1'b0;
    case (opcode)
      7'b0110011: begin
        dec_src = 1'b0;
        case (funct3)
          3'b000: begin
            if (funct7 == 7'b0000000) begin
              kind   = K_R;
              dec_op = OP_ADD;
            end else if (funct7 == 7'b0100000) begin
              kind   = K_R;
              dec_op = OP_SUB;
            end
          end
          3'b111: begin
            kind   = K_R;
            dec_op = OP_AND;
          end
          3'b110: begin
            kind   = K_R;
            dec_op = OP_OR;
          end
          default: kind = K_ILL;
        endcase
      end
      7'b0010011: begin
        dec_src = 1'b1;
        case (funct3)
          3'b000: begin
            kind   = K_I;
            dec_op = OP_ADD;
          end
          3'b111: begin
            kind   = K_I;
            dec_op = OP_AND;
          end
          3'b110: begin
            kind   = K_I;
            dec_op = OP_OR;
          end
          default: kind = K_ILL;
        endcase
      end
      7'b0000011: begin
        dec_src = 1'b1;
        if (funct3 == 3'b011) kind = K_LD;
      end
      7'b0100011: begin
        dec_src = 1'b1;
        if (funct3 == 3'b011) kind = K_SD;
      end
      default: kind = K_ILL;
    endcase
  end

  // State, instruction latch, MEM timeout counter, retire counter, error pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      instr_q   <= 32'd0;
      tmo_q     <= 8'd0;
      retired_q <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      tmo_q     <= tmo_d;
      retired_q <= retired_d;
      mem_err_q <= mem_err_d;
    end
  end

  // Next-state: accept in IDLE, sequence stages, resolve MEM by ack or timeout
  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    tmo_d     = tmo_q;
    retired_d = retired_q;
    mem_err_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.instr_valid) begin
          instr_d = bus.instr_in;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        state_d = (kind == K_ILL) ? S_IDLE : S_EXEC;
      end
      S_EXEC: begin
        tmo_d   = 8'd0;
        state_d = (kind == K_LD || kind == K_SD) ? S_MEM : S_WB;
      end
      S_MEM: begin
        // An ack in the last allowed cycle still completes the access
        if (bus.mem_ack) begin
          if (kind == K_LD) begin
            state_d = S_WB;
          end else begin
            state_d   = S_IDLE;
            retired_d = retired_q + CNT_W'(1);
          end
        end else if (tmo_q == TMO_LAST) begin
          state_d   = S_IDLE;
          mem_err_d = 1'b1;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      S_WB: begin
        state_d   = S_IDLE;
        retired_d = retired_q + CNT_W'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Moore outputs decoded from state and latched instruction
  always_comb begin
    bus.instr_ready = 1'b0;
    bus.RegWrite    = 1'b0;
    bus.ALUSrc      = 1'b0;
    bus.ALUop       = 4'b0000;
    bus.MemWrite    = 1'b0;
    bus.MemRead     = 1'b0;
    bus.MemtoReg    = 1'b0;
    bus.illegal     = 1'b0;
    case (state_q)
      S_IDLE:   bus.instr_ready = 1'b1;
      S_DECODE: bus.illegal     = (kind == K_ILL);
      S_EXEC: begin
        bus.ALUSrc = dec_src;
        bus.ALUop  = dec_op;
      end
      S_MEM: begin
        bus.ALUSrc   = dec_src;
        bus.ALUop    = dec_op;
        bus.MemRead  = (kind == K_LD);
        bus.MemWrite = (kind == K_SD);
      end
      S_WB: begin
        bus.ALUSrc   = dec_src;
        bus.ALUop    = dec_op;
        bus.RegWrite = 1'b1;
        bus.MemtoReg = (kind == K_LD);
      end
      default: bus.instr_ready = 1'b0;
    endcase
  end

  assign bus.instruction = instr_q;
  assign bus.retired     = retired_q;
  assign bus.mem_err     = mem_err_q;
  assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_riscv_ctrl_fsm.sv
// Self-checking bench for riscv_ctrl_fsm: directed cases then randomized
// instructions, each expanded into a per-cycle expected output timeline.
module tb_riscv_ctrl_fsm;

  localparam int CNT_W       = 4;
  localparam int MEM_TIMEOUT = 15;

  localparam int K_ILL = 0;
  localparam int K_R   = 1;
  localparam int K_I   = 2;
  localparam int K_LD  = 3;
  localparam int K_SD  = 4;

  logic       clk;
  logic       reset;
  logic [2:0] dbg_state;

  int n_checks = 0;
  int n_pass   = 0;
  logic [CNT_W-1:0] exp_ret = '0;

  riscv_ctrl_fsm_if #(.CNT_W(CNT_W)) ifc ();

  riscv_ctrl_fsm #(
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .CNT_W      (CNT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (ifc),
    .dbg_state_o(dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference rules ----------------
  typedef struct {
    logic [6:0] opc;
    logic [2:0] f3;
    bit         use_f7;
    logic [6:0] f7;
    int         kind;
    logic [3:0] op;
  } rule_t;

  rule_t rules [9] = '{
    '{7'h33, 3'b000, 1'b1, 7'h00, K_R,  4'b0010},
    '{7'h33, 3'b000, 1'b1, 7'h20, K_R,  4'b0110},
    '{7'h33, 3'b111, 1'b0, 7'h00, K_R,  4'b0000},
    '{7'h33, 3'b110, 1'b0, 7'h00, K_R,  4'b0001},
    '{7'h13, 3'b000, 1'b0, 7'h00, K_I,  4'b0010},
    '{7'h13, 3'b111, 1'b0, 7'h00, K_I,  4'b0000},
    '{7'h13, 3'b110, 1'b0, 7'h00, K_I,  4'b0001},
    '{7'h03, 3'b011, 1'b0, 7'h00, K_LD, 4'b0010},
    '{7'h23, 3'b011, 1'b0, 7'h00, K_SD, 4'b0010}
  };

  task automatic classify(input logic [31:0] ins, output int kind, output logic [3:0] op);
    kind = K_ILL;
    op   = 4'b0000;
    for (int r = 0; r < 9; r++) begin
      if (ins[6:0] == rules[r].opc && ins[14:12] == rules[r].f3 &&
          (!rules[r].use_f7 || ins[31:25] == rules[r].f7)) begin
        kind = rules[r].kind;
        op   = rules[r].op;
      end
    end
  endtask

  // {ready, RegWrite, ALUSrc, ALUop[3:0], MemWrite, MemRead, MemtoReg, illegal, mem_err}
  function automatic logic [11:0] mk(bit rdy, bit rw, bit src, logic [3:0] op,
                                     bit mw, bit mr, bit m2r, bit ill, bit me);
    return {rdy, rw, src, op, mw, mr, m2r, ill, me};
  endfunction

  function automatic logic [11:0] obs();
    return {ifc.instr_ready, ifc.RegWrite, ifc.ALUSrc, ifc.ALUop, ifc.MemWrite,
            ifc.MemRead, ifc.MemtoReg, ifc.illegal, ifc.mem_err};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, got, exp);
  endtask

  // ---------------- driver tasks ----------------
  // Entered and left just after a negedge in an IDLE cycle.
  task automatic run_instr(input string name, input logic [31:0] ins, input int ack_k);
    int         kind;
    logic [3:0] op;
    bit         src;
    bit         acked;
    int         m_cycles;
    logic [11:0] exp_q[$];
    bit          ack_q[$];

    classify(ins, kind, op);
    src = (kind != K_R);

    if (kind == K_ILL) begin
      exp_q.push_back(mk(0, 0, 0, 4'b0000, 0, 0, 0, 1, 0)); ack_q.push_back(1'($urandom_range(0, 1)));
      exp_q.push_back(mk(1, 0, 0, 4'b0000, 0, 0, 0, 0, 0)); ack_q.push_back(1'($urandom_range(0, 1)));
    end else begin
      exp_q.push_back(mk(0, 0, 0, 4'b0000, 0, 0, 0, 0, 0)); ack_q.push_back(1'($urandom_range(0, 1)));
      exp_q.push_back(mk(0, 0, src, op, 0, 0, 0, 0, 0));    ack_q.push_back(1'($urandom_range(0, 1)));
      if (kind == K_R || kind == K_I) begin
        exp_q.push_back(mk(0, 1, src, op, 0, 0, 0, 0, 0));  ack_q.push_back(1'($urandom_range(0, 1)));
        exp_q.push_back(mk(1, 0, 0, 4'b0000, 0, 0, 0, 0, 0)); ack_q.push_back(1'($urandom_range(0, 1)));
        exp_ret = exp_ret + 1'b1;
      end else begin
        acked    = (ack_k >= 1 && ack_k <= MEM_TIMEOUT);
        m_cycles = acked ? ack_k : MEM_TIMEOUT;
        for (int m = 1; m <= m_cycles; m++) begin
          exp_q.push_back(mk(0, 0, src, op, kind == K_SD, kind == K_LD, 0, 0, 0));
          ack_q.push_back(acked && (m == ack_k));
        end
        if (acked && kind == K_LD) begin
          exp_q.push_back(mk(0, 1, src, op, 0, 0, 1, 0, 0)); ack_q.push_back(1'($urandom_range(0, 1)));
        end
        exp_q.push_back(mk(1, 0, 0, 4'b0000, 0, 0, 0, 0, !acked)); ack_q.push_back(1'($urandom_range(0, 1)));
        if (acked) exp_ret = exp_ret + 1'b1;
      end
    end

    ifc.instr_in    = ins;
    ifc.instr_valid = 1'b1;
    ifc.mem_ack     = 1'($urandom_range(0, 1));
    for (int i = 0; i < exp_q.size(); i++) begin
      @(posedge clk);
      #1;
      // Fetch may keep offering junk while busy; it must be ignored
      ifc.instr_valid = (i == exp_q.size() - 1) ? 1'b0 : 1'($urandom_range(0, 1));
      ifc.instr_in    = $urandom();
      ifc.mem_ack     = ack_q[i];
      @(negedge clk);
      check($sformatf("%s ctl c%0d", name, i + 1), {20'd0, obs()}, {20'd0, exp_q[i]});
      if (i == 0) check($sformatf("%s latch", name), ifc.instruction, ins);
    end
    check($sformatf("%s retired", name), {28'd0, ifc.retired}, {28'd0, exp_ret});
    check($sformatf("%s hold", name), ifc.instruction, ins);
    check($sformatf("%s dbg_known", name), {31'd0, $isunknown(dbg_state)}, 32'd0);
  endtask

  task automatic idle_gap(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      ifc.instr_valid = 1'b0;
      ifc.mem_ack     = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("gap idle", {20'd0, obs()}, {20'd0, mk(1, 0, 0, 4'b0000, 0, 0, 0, 0, 0)});
    end
  endtask

  // LD parked in MEM (no ack), reset in its third MEM cycle, then stray acks.
  task automatic reset_mid_ld();
    ifc.instr_in    = 32'h0080B203;
    ifc.instr_valid = 1'b1;
    ifc.mem_ack     = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      ifc.instr_valid = 1'b0;
      ifc.mem_ack     = 1'b0;
      @(negedge clk);
    end
    check("rst_ld in MEM", {20'd0, obs()}, {20'd0, mk(0, 0, 1, 4'b0010, 0, 1, 0, 0, 0)});
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    exp_ret = '0;
    check("rst_ld ctl", {20'd0, obs()}, {20'd0, mk(1, 0, 0, 4'b0000, 0, 0, 0, 0, 0)});
    check("rst_ld retired", {28'd0, ifc.retired}, 32'd0);
    check("rst_ld instruction", ifc.instruction, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      ifc.mem_ack = 1'b1;
      @(negedge clk);
      check("rst_ld stray ack", {20'd0, obs()}, {20'd0, mk(1, 0, 0, 4'b0000, 0, 0, 0, 0, 0)});
    end
    check("rst_ld retired after", {28'd0, ifc.retired}, 32'd0);
    ifc.mem_ack = 1'b0;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [2:0]  f3;
    w = $urandom();
    case ($urandom_range(0, 5))
      0: begin
        w[6:0] = 7'h33;
        case ($urandom_range(0, 2))
          0: w[31:25] = 7'h00;
          1: w[31:25] = 7'h20;
          default: w[31:25] = 7'($urandom());
        endcase
        f3 = 3'($urandom_range(0, 3) == 0 ? $urandom() : 32'(($urandom_range(0, 1) == 0) ? 0 : 6 + $urandom_range(0, 1)));
        w[14:12] = f3;
      end
      1: begin
        w[6:0] = 7'h13;
        if ($urandom_range(0, 3) != 0) w[14:12] = ($urandom_range(0, 1) == 0) ? 3'b000 : 3'(6 + $urandom_range(0, 1));
      end
      2: begin
        w[6:0] = 7'h03;
        if ($urandom_range(0, 3) != 0) w[14:12] = 3'b011;
      end
      3: begin
        w[6:0] = 7'h23;
        if ($urandom_range(0, 3) != 0) w[14:12] = 3'b011;
      end
      4: w[6:0] = 7'h63;
      default: w = w;
    endcase
    return w;
  endfunction

  // ---------------- stimulus + report ----------------
  initial begin
    reset           = 1'b1;
    ifc.instr_in    = 32'd0;
    ifc.instr_valid = 1'b0;
    ifc.mem_ack     = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset ctl", {20'd0, obs()}, {20'd0, mk(1, 0, 0, 4'b0000, 0, 0, 0, 0, 0)});
    check("reset retired", {28'd0, ifc.retired}, 32'd0);
    check("reset instruction", ifc.instruction, 32'd0);
    check("reset dbg_known", {31'd0, $isunknown(dbg_state)}, 32'd0);
    reset = 1'b0;

    run_instr("add",     32'h002081B3, 0);
    run_instr("sub",     32'h402081B3, 0);
    run_instr("ori",     32'h00F0E293, 0);
    run_instr("ld_ack3", 32'h0080B203, 3);
    run_instr("sd_tmo",  32'h0020B823, 0);
    run_instr("branch",  32'h00208463, 0);
    idle_gap(2);
    run_instr("ld_ack1",  32'h0080B203, 1);
    run_instr("sd_ack1",  32'h0020B823, 1);
    run_instr("sd_ack15", 32'h0020B823, 15);
    run_instr("ld_ack15", 32'h0080B203, 15);
    run_instr("ld_tmo",   32'h0080B203, 0);
    run_instr("and",      32'h0020F1B3, 0);
    run_instr("andi",     32'h0FF0F193, 0);
    run_instr("sd_f3bad", 32'h0020A823, 1);
    reset_mid_ld();

    for (int t = 0; t < 80; t++) begin
      run_instr($sformatf("rnd%0d", t), rand_instr(),
                ($urandom_range(0, 3) == 0) ? $urandom_range(13, 16) : $urandom_range(0, 5));
      if ($urandom_range(0, 3) == 0) idle_gap($urandom_range(1, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
